// File: rtl/peak_window3.sv
// peak_window3: per-frame max/min tracker for IEEE-754 single sums. It discards
// a warmup run after each start and reports the in-frame index of each extreme.
module peak_window3 #(
  parameter int FRAME_LEN = 64,
  parameter int WARMUP    = 2,
  parameter int IDXW      = $clog2(FRAME_LEN)
) (
  input  logic            clock,
  input  logic            aclr,
  input  logic            clk_en,
  input  logic            start,
  input  logic            in_valid,
  input  logic [31:0]     in_data,
  output logic            busy,
  output logic            frame_done,
  output logic [31:0]     max_out,
  output logic [31:0]     min_out,
  output logic [IDXW-1:0] max_idx,
  output logic [IDXW-1:0] min_idx,
  output logic            nan_seen
);
  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_ACCUM, S_DONE} state_t;

  localparam logic [31:0]     QNAN     = 32'h7FC0_0000;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);
  // Unreachable when WARMUP=0, because IDLE then bypasses the WARMUP state.
  localparam logic [3:0]      WU_LAST  = 4'(WARMUP - 1);

  state_t          state, state_nxt;
  logic [3:0]      wcnt;
  logic [IDXW-1:0] scnt;
  logic            trk_vld, nan_flag;
  logic [31:0]     trk_max, trk_min;
  logic [IDXW-1:0] trk_max_idx, trk_min_idx;

  logic            n_vld, n_nan;
  logic [31:0]     n_max, n_min;
  logic [IDXW-1:0] n_max_idx, n_min_idx;

  logic        take, last, in_nan;
  logic [31:0] in_key;

  // Map floats to unsigned keys:
  // -inf < negatives < -0 < +0 < positives < +inf.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  assign take   = (state == S_ACCUM) && in_valid;
  assign last   = take && (scnt == LAST_IDX);
  assign in_nan = (in_data[30:23] == 8'hFF) && (in_data[22:0] != '0);
  assign in_key = fkey(in_data);

  assign busy       = (state == S_WARMUP) || (state == S_ACCUM);
  assign frame_done = (state == S_DONE);

  // Tracker contents after the current sample is taken.
  // Strict compares make the earliest index win on ties.
  always_comb begin
    n_vld     = trk_vld;
    n_nan     = nan_flag;
    n_max     = trk_max;
    n_min     = trk_min;
    n_max_idx = trk_max_idx;
    n_min_idx = trk_min_idx;
    if (in_nan) begin
      n_nan = 1'b1;
    end else if (!trk_vld) begin
      n_vld     = 1'b1;
      n_max     = in_data;
      n_min     = in_data;
      n_max_idx = scnt;
      n_min_idx = scnt;
    end else begin
      if (in_key > fkey(trk_max)) begin
        n_max     = in_data;
        n_max_idx = scnt;
      end
      if (in_key < fkey(trk_min)) begin
        n_min     = in_data;
        n_min_idx = scnt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (WARMUP == 0) ? S_ACCUM : S_WARMUP;
      S_WARMUP: if (in_valid && (wcnt == WU_LAST)) state_nxt = S_ACCUM;
      S_ACCUM:  if (last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) state <= S_IDLE;
    else if (clk_en) state <= state_nxt;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wcnt        <= '0;
      scnt        <= '0;
      trk_vld     <= 1'b0;
      nan_flag    <= 1'b0;
      trk_max     <= '0;
      trk_min     <= '0;
      trk_max_idx <= '0;
      trk_min_idx <= '0;
      max_out     <= '0;
      min_out     <= '0;
      max_idx     <= '0;
      min_idx     <= '0;
      nan_seen    <= 1'b0;
    end else if (clk_en) begin
      case (state)
        S_IDLE: if (start) begin
          wcnt     <= '0;
          scnt     <= '0;
          trk_vld  <= 1'b0;
          nan_flag <= 1'b0;
        end
        S_WARMUP: if (in_valid) wcnt <= wcnt + 4'd1;
        S_ACCUM: if (in_valid) begin
          scnt        <= scnt + 1'b1;
          trk_vld     <= n_vld;
          nan_flag    <= n_nan;
          trk_max     <= n_max;
          trk_min     <= n_min;
          trk_max_idx <= n_max_idx;
          trk_min_idx <= n_min_idx;
        end
        default: ;
      endcase
      // Load the results while entering DONE, so they are valid alongside frame_done.
      if (last) begin
        max_out  <= n_vld ? n_max : QNAN;
        min_out  <= n_vld ? n_min : QNAN;
        max_idx  <= n_vld ? n_max_idx : '0;
        min_idx  <= n_vld ? n_min_idx : '0;
        nan_seen <= n_nan;
      end
    end
  end
endmodule
